bcd_operand_entry: RTL



---
 rtl/bcd_operand_entry.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : bcd_operand_entry
// Brief    : Keypad front end that assembles signed BCD operands for the ALU.
//            Optional macro BCD_ENTRY_BACKSPACE_EN enables the BKSP key.
// Revision : 1.0
// ============================================================================
module bcd_operand_entry #(
   parameter int DIGIT_NUM = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   key_valid,
   input  logic [4:0]             key_code,
   output logic                   key_ready,
   output logic [4*DIGIT_NUM-1:0] operand0,
   output logic                   operand0_sign,
   output logic [4*DIGIT_NUM-1:0] operand1,
   output logic                   operand1_sign,
   output logic [2:0]             operation,
   output logic                   op_valid,
   input  logic [4*DIGIT_NUM-1:0] alu_result,
   input  logic                   alu_result_sign,
   input  logic                   alu_flag_ov,
   output logic [4*DIGIT_NUM-1:0] display,
   output logic                   display_sign,
   output logic                   display_err
);

   localparam int W  = 4 * DIGIT_NUM;
   localparam int CW = $clog2(DIGIT_NUM + 1);

   localparam logic [CW-1:0] c_cnt_max  = CW'(DIGIT_NUM);
   localparam logic [4:0]    c_key_neg  = 5'h18;
   localparam logic [4:0]    c_key_eq   = 5'h19;
   localparam logic [4:0]    c_key_clr  = 5'h1A;
   localparam logic [4:0]    c_key_bksp = 5'h1B;

   typedef enum logic [2:0] {
      ST_ENTER_A = 3'd0,
      ST_ENTER_B = 3'd1,
      ST_EXEC    = 3'd2,
      ST_SHOW    = 3'd3,
      ST_ERROR   = 3'd4
   } state_t;

   state_t          r_state;
   logic [W-1:0]    r_a;
   logic            r_a_sign;
   logic [CW-1:0]   r_a_cnt;
   logic [W-1:0]    r_b;
   logic            r_b_sign;
   logic [CW-1:0]   r_b_cnt;
   logic [2:0]      r_operation;
   logic            r_op_valid;
   logic            r_pending_valid;
   logic [2:0]      r_pending_op;
   logic [W-1:0]    r_result;
   logic            r_result_sign;
   logic [W-1:0]    r_disp;
   logic            r_disp_sign;
   logic            r_disp_err;

   logic            w_accept;
   logic            w_is_digit;
   logic            w_is_op;
   logic            w_is_edit;
   logic [3:0]      w_digit;
   logic            w_in_b;
   logic [W-1:0]    w_cur_val;
   logic            w_cur_sign;
   logic [CW-1:0]   w_cur_cnt;
   logic [W-1:0]    w_edit_val;
   logic            w_edit_sign;
   logic [CW-1:0]   w_edit_cnt;
   logic            w_alu_sign;
   logic [CW-1:0]   w_alu_cnt;
   logic [CW-1:0]   w_res_cnt;

   // Number of significant digits, so a result reused as A keeps editing sanely.
   function automatic logic [CW-1:0] sig_digits(input logic [W-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < DIGIT_NUM; i++) begin
         if (v[4*i +: 4] != 4'd0) n = CW'(i + 1);
      end
      return n;
   endfunction

   assign key_ready  = (r_state != ST_EXEC);
   assign w_accept   = key_valid && key_ready;
   assign w_is_digit = (key_code <= 5'h09);
   assign w_is_op    = (key_code[4:3] == 2'b10) && (key_code[2:0] <= 3'd4);
   assign w_is_edit  = w_is_digit || (key_code == c_key_neg) || (key_code == c_key_bksp);
   assign w_digit    = key_code[3:0];

   assign w_in_b     = (r_state == ST_ENTER_B);
   assign w_cur_val  = w_in_b ? r_b      : r_a;
   assign w_cur_sign = w_in_b ? r_b_sign : r_a_sign;
   assign w_cur_cnt  = w_in_b ? r_b_cnt  : r_a_cnt;

   assign w_alu_sign = alu_result_sign && (alu_result != '0);
   assign w_alu_cnt  = sig_digits(alu_result);
   assign w_res_cnt  = sig_digits(r_result);

   always_comb begin
      w_edit_val  = w_cur_val;
      w_edit_sign = w_cur_sign;
      w_edit_cnt  = w_cur_cnt;
      if (w_is_digit) begin
         if ((w_cur_cnt < c_cnt_max) && !((w_digit == 4'd0) && (w_cur_cnt == '0))) begin
            w_edit_val = {w_cur_val[W-5:0], w_digit};
            w_edit_cnt = w_cur_cnt + 1'b1;
         end
      end else if (key_code == c_key_neg) begin
         w_edit_sign = ~w_cur_sign;
      end
`ifdef BCD_ENTRY_BACKSPACE_EN
      else if ((key_code == c_key_bksp) && (w_cur_cnt != '0)) begin
         w_edit_val = w_cur_val >> 4;
         w_edit_cnt = w_cur_cnt - 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_ENTER_A;
         r_a             <= '0;
         r_a_sign        <= 1'b0;
         r_a_cnt         <= '0;
         r_b             <= '0;
         r_b_sign        <= 1'b0;
         r_b_cnt         <= '0;
         r_operation     <= 3'b000;
         r_op_valid      <= 1'b0;
         r_pending_valid <= 1'b0;
         r_pending_op    <= 3'b000;
         r_result        <= '0;
         r_result_sign   <= 1'b0;
         r_disp          <= '0;
         r_disp_sign     <= 1'b0;
         r_disp_err      <= 1'b0;
      end else if (r_state == ST_EXEC) begin
         // Single-cycle execute: the ALU result is sampled on the exit edge.
         r_op_valid      <= 1'b0;
         r_pending_valid <= 1'b0;
         r_result        <= alu_result;
         r_result_sign   <= w_alu_sign;
         if (alu_flag_ov) begin
            r_state     <= ST_ERROR;
            r_disp      <= '0;
            r_disp_sign <= 1'b0;
            r_disp_err  <= 1'b1;
         end else if (r_pending_valid) begin
            r_state     <= ST_ENTER_B;
            r_a         <= alu_result;
            r_a_sign    <= w_alu_sign;
            r_a_cnt     <= w_alu_cnt;
            r_b         <= '0;
            r_b_sign    <= 1'b0;
            r_b_cnt     <= '0;
            r_operation <= r_pending_op;
            r_disp      <= alu_result;
            r_disp_sign <= w_alu_sign;
         end else begin
            r_state     <= ST_SHOW;
            r_disp      <= alu_result;
            r_disp_sign <= w_alu_sign;
         end
      end else if (w_accept && (key_code == c_key_clr)) begin
         r_state         <= ST_ENTER_A;
         r_a             <= '0;
         r_a_sign        <= 1'b0;
         r_a_cnt         <= '0;
         r_b             <= '0;
         r_b_sign        <= 1'b0;
         r_b_cnt         <= '0;
         r_operation     <= 3'b000;
         r_op_valid      <= 1'b0;
         r_pending_valid <= 1'b0;
         r_pending_op    <= 3'b000;
         r_result        <= '0;
         r_result_sign   <= 1'b0;
         r_disp          <= '0;
         r_disp_sign     <= 1'b0;
         r_disp_err      <= 1'b0;
      end else if (w_accept) begin
         case (r_state)
            ST_ENTER_A: begin
               if (w_is_edit) begin
                  r_a         <= w_edit_val;
                  r_a_sign    <= w_edit_sign;
                  r_a_cnt     <= w_edit_cnt;
                  r_disp      <= w_edit_val;
                  r_disp_sign <= w_edit_sign;
               end else if (w_is_op) begin
                  r_operation <= key_code[2:0];
                  r_b         <= '0;
                  r_b_sign    <= 1'b0;
                  r_b_cnt     <= '0;
                  r_state     <= ST_ENTER_B;
               end
            end
            ST_ENTER_B: begin
               if (w_is_edit) begin
                  r_b         <= w_edit_val;
                  r_b_sign    <= w_edit_sign;
                  r_b_cnt     <= w_edit_cnt;
                  // An empty B still shows A so the user sees the first operand.
                  r_disp      <= (w_edit_cnt != '0) ? w_edit_val  : r_a;
                  r_disp_sign <= (w_edit_cnt != '0) ? w_edit_sign : r_a_sign;
               end else if (w_is_op) begin
                  if (r_b_cnt == '0) begin
                     r_operation <= key_code[2:0];
                  end else begin
                     r_pending_valid <= 1'b1;
                     r_pending_op    <= key_code[2:0];
                     r_op_valid      <= 1'b1;
                     r_state         <= ST_EXEC;
                  end
               end else if ((key_code == c_key_eq) && (r_b_cnt != '0)) begin
                  r_pending_valid <= 1'b0;
                  r_op_valid      <= 1'b1;
                  r_state         <= ST_EXEC;
               end
            end
            ST_SHOW: begin
               if (w_is_digit) begin
                  r_a         <= {{(W-4){1'b0}}, w_digit};
                  r_a_sign    <= 1'b0;
                  r_a_cnt     <= (w_digit != 4'd0) ? CW'(1) : '0;
                  r_disp      <= {{(W-4){1'b0}}, w_digit};
                  r_disp_sign <= 1'b0;
                  r_state     <= ST_ENTER_A;
               end else if (w_is_op) begin
                  r_a         <= r_result;
                  r_a_sign    <= r_result_sign;
                  r_a_cnt     <= w_res_cnt;
                  r_operation <= key_code[2:0];
                  r_b         <= '0;
                  r_b_sign    <= 1'b0;
                  r_b_cnt     <= '0;
                  r_disp      <= r_result;
                  r_disp_sign <= r_result_sign;
                  r_state     <= ST_ENTER_B;
               end else if (key_code == c_key_neg) begin
                  r_a         <= r_result;
                  r_a_sign    <= ~r_result_sign;
                  r_a_cnt     <= w_res_cnt;
                  r_disp      <= r_result;
                  r_disp_sign <= ~r_result_sign;
                  r_state     <= ST_ENTER_A;
               end else if (key_code == c_key_eq) begin
                  r_a             <= r_result;
                  r_a_sign        <= r_result_sign;
                  r_a_cnt         <= w_res_cnt;
                  r_pending_valid <= 1'b0;
                  r_op_valid      <= 1'b1;
                  r_state         <= ST_EXEC;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign operand0      = r_a;
   assign operand0_sign = r_a_sign;
   assign operand1      = r_b;
   assign operand1_sign = r_b_sign;
   assign operation     = r_operation;
   assign op_valid      = r_op_valid;
   assign display       = r_disp;
   assign display_sign  = r_disp_sign;
   assign display_err   = r_disp_err;

endmodule
`default_nettype wire
